// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - CSR addresses, FSM encoding and vector helper for the interrupt controller
package interrupt_controller_pkg;

    localparam logic [1:0] IC_CSR_MASK    = 2'd0;
    localparam logic [1:0] IC_CSR_MODE    = 2'd1;
    localparam logic [1:0] IC_CSR_PENDING = 2'd2;
    localparam logic [1:0] IC_CSR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_TAKE = 2'b10
    } ic_state_e;

    // 16-bit wrap is intentional: the vector table may straddle the top of memory.
    function automatic logic [15:0] ic_vector(input logic [15:0] base,
                                              input int unsigned stride_log2,
                                              input logic [3:0] id);
        return base + (16'(id) << stride_log2);
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - core-side commit/CSR/take signals of the interrupt controller
interface interrupt_controller_if;
    logic        COMMIT;
    logic        EIX;
    logic        DIX;
    logic        RETIX;
    logic [1:0]  CSR_ADDR;
    logic        CSR_WR;
    logic [15:0] CSR_DIN;
    logic [15:0] CSR_DOUT;
    logic        INT_REQ;
    logic        INT_TAKEX;
    logic [15:0] INT_VECTOR;
    logic [3:0]  INT_ID;

    modport master (
        output COMMIT, EIX, DIX, RETIX, CSR_ADDR, CSR_WR, CSR_DIN,
        input  CSR_DOUT, INT_REQ, INT_TAKEX, INT_VECTOR, INT_ID
    );

    modport slave (
        input  COMMIT, EIX, DIX, RETIX, CSR_ADDR, CSR_WR, CSR_DIN,
        output CSR_DOUT, INT_REQ, INT_TAKEX, INT_VECTOR, INT_ID
    );
endinterface

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// rtl/interrupt_controller_irq_priority_encoder.sv - fixed-priority encoder, lowest set index wins
module irq_priority_encoder #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [3:0]         id
);

    always_comb begin
        valid = 1'b0;
        id    = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - vectored, nesting, fixed-priority interrupt controller
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ         = 8,
    parameter logic [15:0] VEC_BASE        = 16'h0010,
    parameter int          VEC_STRIDE_LOG2 = 2,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [NUM_IRQ-1:0]   IRQ,
    interrupt_controller_if.slave bus
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] active_q, active_d;
    logic               gie_q, gie_d;
    ic_state_e          state_q, state_d;
    logic               int_req_q, int_req_d;
    logic               int_takex_q, int_takex_d;
    logic [15:0]        vector_q, vector_d;
    logic [3:0]         id_q, id_d;

    logic [NUM_IRQ-1:0] synced, rise, pending, eligible;
    logic [NUM_IRQ-1:0] prio_mask, take_mask, pop_mask, csr_wdata, w1c;
    logic               act_valid, win_valid;
    logic [3:0]         act_id, win_id;
    logic               ctl_op, take, retire;
    logic               unused_din;

    assign synced     = sync_q[SYNC_STAGES-1];
    assign rise       = synced & ~prev_q;
    // Level channels bypass the stored bit and follow the synchronised pin.
    assign pending    = (mode_q & pend_q) | (~mode_q & synced);
    assign eligible   = pending & mask_q & {NUM_IRQ{gie_q}} & prio_mask;
    assign csr_wdata  = bus.CSR_DIN[NUM_IRQ-1:0];
    assign unused_din = ^bus.CSR_DIN;

    assign ctl_op = bus.EIX | bus.DIX | bus.RETIX;
    assign take   = (state_q == ST_REQ) && win_valid && bus.COMMIT && !ctl_op;
    assign retire = bus.COMMIT && bus.RETIX && act_valid;

    irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_active_enc (
        .req   (active_q),
        .valid (act_valid),
        .id    (act_id)
    );

    irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_winner_enc (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            prio_mask[i] = !act_valid || (4'(i) < act_id);
            take_mask[i] = take && (win_id == 4'(i));
            pop_mask[i]  = retire && (act_id == 4'(i));
        end
    end

    always_comb begin
        sync_d[0] = IRQ;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = synced;

        mask_d = mask_q;
        mode_d = mode_q;
        w1c    = '0;
        if (bus.CSR_WR) begin
            case (bus.CSR_ADDR)
                IC_CSR_MASK:    mask_d = csr_wdata;
                IC_CSR_MODE:    mode_d = csr_wdata;
                IC_CSR_PENDING: w1c    = csr_wdata;
                default:        ;
            endcase
        end

        // A fresh rising edge outranks both W1C and the take clear.
        pend_d   = ((pend_q & ~w1c & ~take_mask) | rise) & mode_q;
        active_d = (active_q | take_mask) & ~pop_mask;

        gie_d = gie_q;
        if (bus.COMMIT && bus.DIX) begin
            gie_d = 1'b0;
        end else if (bus.COMMIT && (bus.EIX || bus.RETIX)) begin
            gie_d = 1'b1;
        end else if (take) begin
            gie_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        int_req_d   = int_req_q;
        int_takex_d = 1'b0;
        vector_d    = vector_q;
        id_d        = id_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d   = ST_REQ;
                    int_req_d = 1'b1;
                end else begin
                    int_req_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (!win_valid) begin
                    state_d   = ST_IDLE;
                    int_req_d = 1'b0;
                end else if (take) begin
                    state_d     = ST_TAKE;
                    int_req_d   = 1'b0;
                    int_takex_d = 1'b1;
                    id_d        = win_id;
                    vector_d    = ic_vector(VEC_BASE, VEC_STRIDE_LOG2, win_id);
                end
            end
            ST_TAKE: begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q      <= '0;
            mask_q      <= '0;
            mode_q      <= '1;
            pend_q      <= '0;
            active_q    <= '0;
            gie_q       <= 1'b0;
            state_q     <= ST_IDLE;
            int_req_q   <= 1'b0;
            int_takex_q <= 1'b0;
            vector_q    <= 16'h0000;
            id_q        <= 4'd0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q      <= prev_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            active_q    <= active_d;
            gie_q       <= gie_d;
            state_q     <= state_d;
            int_req_q   <= int_req_d;
            int_takex_q <= int_takex_d;
            vector_q    <= vector_d;
            id_q        <= id_d;
        end
    end

    always_comb begin
        case (bus.CSR_ADDR)
            IC_CSR_MASK:    bus.CSR_DOUT = 16'(mask_q);
            IC_CSR_MODE:    bus.CSR_DOUT = 16'(mode_q);
            IC_CSR_PENDING: bus.CSR_DOUT = 16'(pending);
            default:        bus.CSR_DOUT = {gie_q, act_valid, 10'd0, act_id};
        endcase
    end

    assign bus.INT_REQ    = int_req_q;
    assign bus.INT_TAKEX  = int_takex_q;
    assign bus.INT_VECTOR = vector_q;
    assign bus.INT_ID     = id_q;

endmodule
